// File: rtl/elastic_fifo_sync_if.sv
// Valid/ready handshake bundle for elastic_fifo_sync: upstream ins channel, downstream outs channel.
// The FIFO takes the slave view; a producer/consumer pair (or a bench) takes the master view.
interface elastic_fifo_sync_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/elastic_fifo_sync.sv
// Single-clock elastic FIFO: register array with head/tail pointers and an occupancy counter.
// Ready/valid depend only on the counter, so there is no combinational path between the two sides.
module elastic_fifo_sync #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_SLOTS  = 4
) (
    input logic                clk,
    input logic                rst,
    elastic_fifo_sync_if.slave bus
);
    localparam int unsigned PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_SLOTS - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push, pop;

    assign bus.ins_ready  = (count_q != FullCnt);
    assign bus.outs_valid = (count_q != '0);
    assign bus.outs       = mem_q[head_q];

    assign push = bus.ins_valid && bus.ins_ready;
    assign pop  = bus.outs_valid && bus.outs_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the slot at tail is ever written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[tail_q] <= bus.ins;
        end
    end
endmodule

// File: doc/elastic_fifo_sync.md
ELASTIC_FIFO_SYNC -- requirements
Module: elastic_fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the ins/outs data path (matches extui OUTPUT_WIDTH).
REQ-002 Parameter NUM_SLOTS, default 4, storage depth in tokens; legal range 2..256, not restricted to powers of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ins  input  DATA_WIDTH  upstream data token.
REQ-006 ins_valid  input  1  upstream token present.
REQ-007 ins_ready  output  1  block accepts a token this cycle.
REQ-008 outs  output  DATA_WIDTH  head-of-queue data token.
REQ-009 outs_valid  output  1  head token present.
REQ-010 outs_ready  input  1  downstream consumes head token this cycle.

Function
REQ-011 Push = ins_valid && ins_ready; pop = outs_valid && outs_ready; both evaluated on the same clock edge.
REQ-012 Storage: NUM_SLOTS x DATA_WIDTH register array, head pointer, tail pointer, occupancy counter of width clog2(NUM_SLOTS+1).
REQ-013 ins_ready SHALL be 1 exactly when count < NUM_SLOTS; no combinational path from outs_ready to ins_ready.
REQ-014 outs_valid SHALL be 1 exactly when count > 0; no combinational path from ins_valid to outs_valid.
REQ-015 outs SHALL equal the array entry at head; its value is unspecified while outs_valid = 0 and is not checked.
REQ-016 Latency: token pushed at edge N is visible on outs with outs_valid = 1 no earlier than the cycle after edge N (minimum latency 1 cycle, no bypass).
REQ-017 Push writes ins into slot tail and advances tail; pop advances head; data SHALL leave in arrival order.
REQ-018 Pointer wrap: a pointer at NUM_SLOTS-1 advances to 0; no other wrap value.
REQ-019 Count update: push only -> count+1; pop only -> count-1; both -> unchanged; neither -> unchanged.
REQ-020 Full (count = NUM_SLOTS): ins_ready = 0, no push regardless of ins_valid or outs_ready; a pop that cycle frees a slot for the next cycle.
REQ-021 Empty (count = 0): outs_valid = 0, no pop regardless of outs_ready; a push that cycle makes outs_valid = 1 next cycle.
REQ-022 Simultaneous push and pop at any 0 < count < NUM_SLOTS SHALL sustain one token per cycle throughput.
REQ-023 Array contents SHALL change only on push, and only in slot tail.
REQ-024 outs and outs_valid SHALL hold stable while outs_valid = 1 and outs_ready = 0 (elastic hold rule).

Reset
REQ-025 rst = 1 at an edge SHALL set head = 0, tail = 0, count = 0; array contents are not reset.
REQ-026 During and immediately after reset: outs_valid = 0, ins_ready = 1.
REQ-027 Reset asserted mid-operation SHALL discard all stored tokens, overriding any push or pop that cycle.
REQ-028 First push is accepted on the first edge with rst = 0 and ins_valid = 1.

Verification
REQ-029 Fill/drain: NUM_SLOTS=4, push 0x11,0x22,0x33,0x44 with outs_ready=0 -> ins_ready=0 after 4th push, outs=0x11 held; then outs_ready=1 -> outs 0x11,0x22,0x33,0x44 on consecutive cycles, then outs_valid=0.
REQ-030 Streaming: ins_valid=outs_ready=1 continuously, incrementing data from 0 -> after 1-cycle latency outs increments by 1 every cycle, count stays 1, no gaps.
REQ-031 Full with simultaneous pop: count=4, ins_valid=1, outs_ready=1 -> no push that cycle, count=3, ins_ready=1 next cycle, next push accepted.
REQ-032 Wrap-around: NUM_SLOTS=3, push/pop 10 tokens 0xA0..0xA9 with random ins_valid/outs_ready -> output order exactly 0xA0..0xA9, no loss or duplication.
REQ-033 Reset mid-operation: count=2, assert rst one cycle with ins_valid=outs_ready=1 -> next cycle outs_valid=0, ins_ready=1, count=0; prior tokens never appear on outs.
REQ-034 Backpressure hold: outs_valid=1, outs_ready=0 for 5 cycles while pushing -> outs and outs_valid unchanged across all 5 cycles.
